// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared types and sizes for the line-to-burst adaptor
package cacheline_adaptor_pkg;
  localparam int s_line = 256;
  localparam int s_burst = 64;
  localparam int s_offset = 5;
  localparam int num_beats = s_line / s_burst;
  localparam int cnt_w = $clog2(num_beats);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;
  typedef logic [s_line-1:0] line_t;
  typedef logic [s_burst-1:0] beat_t;
endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns 256-bit cache line transactions into 4-beat 64-bit memory bursts
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  line_t       line_i,
  output line_t       line_o,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  output logic        resp_o,
  input  beat_t       burst_i,
  output beat_t       burst_o,
  output logic [31:0] address_o,
  output logic        read_o,
  output logic        write_o,
  input  logic        resp_i
);
  adaptor_state_t state, state_n;
  logic [cnt_w-1:0] cnt;
  line_t rline, wline;
  logic [31:0] addr;
  logic last_beat;
  assign last_beat = resp_i && cnt == cnt_w'(num_beats - 1);
  // next state: write beats read when both are requested; bursts end on the last accepted beat
  always_comb begin
    state_n = state == IDLE ? (write_i ? WRITE : read_i ? READ : IDLE)
            : state == DONE ? IDLE
            : last_beat ? DONE : state;
  end
  // state, beat counter, latched address and separate read/write line buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rline <= '0;
      wline <= '0;
      addr <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (read_i || write_i)) begin
        addr <= {address_i[31:s_offset], s_offset'(0)};
        cnt <= '0;
      end
      if (state == IDLE && write_i) wline <= line_i;
      if ((state == READ || state == WRITE) && resp_i) cnt <= cnt + cnt_w'(1);
      if (state == READ && resp_i) rline[s_burst*cnt +: s_burst] <= burst_i;
    end
  end
  // outputs decode the registered state; the read line only changes when a read beat lands
  always_comb begin
    read_o = state == READ;
    write_o = state == WRITE;
    resp_o = state == DONE;
    address_o = (state == READ || state == WRITE) ? addr : '0;
    burst_o = state == WRITE ? wline[s_burst*cnt +: s_burst] : '0;
    line_o = rline;
  end
endmodule
